// File: rtl/reg_dump_reader.sv
// Debug read-out engine: snapshots every register of the bank through its read port,
// then streams a framed dump (header, register bytes, XOR checksum) over valid/ready.
module reg_dump_reader #(
    parameter int                    NUM_REGS   = 8,
    parameter int                    SEL_WIDTH  = 3,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] HEADER     = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [SEL_WIDTH-1:0]  reg_sel,
    input  logic [DATA_WIDTH-1:0] reg_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SEND_HDR,
        S_SEND_REG,
        S_SEND_SUM,
        S_DONE
    } state_t;

    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_REGS - 1);

    state_t                  state_q, state_d;
    logic [SEL_WIDTH-1:0]    idx_q, idx_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   snap_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   snap_d [NUM_REGS];
    logic [DATA_WIDTH-1:0]   sum_q, sum_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [SEL_WIDTH-1:0]    idx_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            sel_q   <= '0;
            snap_q  <= '{default: '0};
            sum_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            snap_q  <= snap_d;
            sum_q   <= sum_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Every output is computed one edge ahead so the ports come straight from flops.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        snap_d  = snap_q;
        sum_d   = sum_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        idx_inc = idx_q + SEL_WIDTH'(1);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CAPTURE;
                    idx_d   = '0;
                    sel_d   = '0;
                    sum_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_CAPTURE: begin
                snap_d[idx_q] = reg_data;
                sum_d         = sum_q ^ reg_data;
                if (idx_q == LAST_IDX) begin
                    state_d = S_SEND_HDR;
                    idx_d   = '0;
                    sel_d   = '0;
                    valid_d = 1'b1;
                    data_d  = HEADER;
                end else begin
                    idx_d = idx_inc;
                    sel_d = idx_inc;
                end
            end
            S_SEND_HDR: begin
                if (out_ready) begin
                    state_d = S_SEND_REG;
                    data_d  = snap_q[0];
                end
            end
            S_SEND_REG: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_SEND_SUM;
                        idx_d   = '0;
                        data_d  = sum_q;
                    end else begin
                        idx_d  = idx_inc;
                        data_d = snap_q[idx_inc];
                    end
                end
            end
            S_SEND_SUM: begin
                if (out_ready) begin
                    state_d = S_DONE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    data_d  = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign reg_sel   = sel_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Testbench for reg_dump_reader: a bank model feeds the read port, expected frames are
// queued at each start and a monitor pops and compares every transferred byte.
module tb_reg_dump_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       out_ready = 1'b1;
    logic [2:0] reg_sel;
    logic [7:0] reg_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       done;

    logic [7:0] bank  [8];
    logic [7:0] model [8];
    logic [7:0] expQ  [$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         doneSeen = 0;
    int         framesExp = 0;
    int         readyMode = 0;
    int         rdyCnt = 0;

    reg_dump_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .reg_sel   (reg_sel),
        .reg_data  (reg_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    assign reg_data = bank[reg_sel];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer back-pressure: always ready, random, or the 1,0,0 repeating pattern.
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: begin
                out_ready = (rdyCnt % 3 == 0);
                rdyCnt++;
            end
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: a byte transfers at the next edge when valid and ready are both seen here.
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                checkOutput("stall_valid_held", 32'(out_valid), 32'd1);
                checkOutput("stall_data_stable", 32'(out_data), 32'(pd));
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_byte actual=%0h expected=none", out_data);
                end else begin
                    checkOutput("stream_byte", 32'(out_data), 32'(expQ.pop_front()));
                end
            end
            if (done) begin
                doneSeen++;
                checkOutput("done_frame_boundary", 32'(expQ.size() % 10), 32'd0);
                checkOutput("done_valid_low", 32'(out_valid), 32'd0);
            end
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic copyBankToModel();
        for (int i = 0; i < 8; i++) model[i] = bank[i];
    endtask

    // Reference frame: header, each snapshotted byte, then XOR of those bytes only.
    task automatic pushModelFrame();
        logic [7:0] x;
        x = 8'h00;
        expQ.push_back(8'hA5);
        for (int i = 0; i < 8; i++) begin
            expQ.push_back(model[i]);
            x = x ^ model[i];
        end
        expQ.push_back(x);
        framesExp++;
    endtask

    task automatic applyStimulus();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout actual=no_done expected=done", tag);
        end
        tick();
    endtask

    task automatic presetBank();
        for (int i = 0; i < 8; i++) bank[i] = 8'((i + 1) * 8'h11);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e;
        int k;
        presetBank();
        repeat (3) tick();
        checkOutput("rst_reg_sel", 32'(reg_sel), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        // Preset bank, always ready, exact cycle timing.
        copyBankToModel();
        pushModelFrame();
        applyStimulus();
        e = cyc;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            k = cyc - e + 1;
            checkOutput("t1_busy", 32'(busy), 32'(k >= 1 && k <= 18));
            checkOutput("t1_done", 32'(done), 32'(k == 19));
            checkOutput("t1_valid", 32'(out_valid), 32'(k >= 9 && k <= 18));
            if (k >= 1 && k <= 8) checkOutput("t1_reg_sel", 32'(reg_sel), 32'(k - 1));
        end
        tick();

        // All-zero bank.
        for (int i = 0; i < 8; i++) bank[i] = 8'h00;
        copyBankToModel();
        pushModelFrame();
        applyStimulus();
        waitDone("zero");

        // Preset bank with 1,0,0 back-pressure.
        presetBank();
        copyBankToModel();
        readyMode = 2;
        rdyCnt = 0;
        pushModelFrame();
        applyStimulus();
        waitDone("stall");
        readyMode = 0;
        tick();

        // start held high: second dump accepted only at edge E+20.
        copyBankToModel();
        pushModelFrame();
        pushModelFrame();
        start = 1'b1;
        tick();
        e = cyc;
        for (int n = 0; n < 22; n++) begin
            @(negedge clk);
            k = cyc - e + 1;
            checkOutput("held_busy", 32'(busy), 32'(k <= 18 || k >= 21));
        end
        tick();
        start = 1'b0;
        waitDone("held");
        checkOutput("held_frames", 32'(doneSeen), 32'(framesExp));

        // Start pulses while busy are ignored.
        pushModelFrame();
        applyStimulus();
        repeat (3) tick();
        applyStimulus();
        repeat (8) tick();
        applyStimulus();
        waitDone("ignore");
        repeat (25) tick();
        checkOutput("ignore_idle_busy", 32'(busy), 32'd0);
        checkOutput("ignore_frames", 32'(doneSeen), 32'(framesExp));

        // Reset while register byte 4 is on the stream.
        pushModelFrame();
        applyStimulus();
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            if (out_valid && out_data == 8'h55) break;
            k++;
        end
        checkOutput("abort_reached_byte4", 32'(k < 100), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        expQ.delete();
        framesExp--;
        checkOutput("abort_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        pushModelFrame();
        applyStimulus();
        waitDone("after_reset");

        // Bank write to reg 6 at the edge when reg_sel is 2.
        presetBank();
        copyBankToModel();
        model[6] = 8'h00;
        pushModelFrame();
        applyStimulus();
        repeat (2) tick();
        checkOutput("wr_reg_sel", 32'(reg_sel), 32'd2);
        tick();
        bank[6] = 8'h00;
        waitDone("bank_write");

        // Randomized banks with random back-pressure.
        readyMode = 1;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) bank[i] = 8'($urandom);
            copyBankToModel();
            pushModelFrame();
            applyStimulus();
            waitDone("random");
            repeat (int'($urandom_range(0, 3))) tick();
        end
        readyMode = 0;
        repeat (3) tick();

        checkOutput("final_frames", 32'(doneSeen), 32'(framesExp));
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
